// File: rtl/aq_axis_capture.sv
// AXI4-Stream frame capture: counts, checksums and buffers one frame of beats
// into a dual-address RAM, flagging framing errors and buffer overflow.
module aq_axis_capture #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TKEEP,
  input  logic [DATA_W/8-1:0] S_AXIS_TSTRB,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic                FSYNC_IN,
  input  logic [15:0]         CFG_WIDTH,
  input  logic [15:0]         CFG_HEIGHT,
  input  logic [7:0]          STALL_MASK,
  input  logic [ADDR_W-1:0]   RD_ADDR,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic [31:0]         PIX_COUNT,
  output logic [31:0]         CHECKSUM,
  output logic                ERR_EARLY_LAST,
  output logic                ERR_NO_LAST,
  output logic                ERR_OVERFLOW
);

  localparam logic [32:0] Depth = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [31:0] pix_count_q, pix_count_d;
  logic [31:0] checksum_q, checksum_d;
  logic [31:0] frame_size_q, frame_size_d;
  logic [15:0] width_q, width_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        done_q, done_d;
  logic        err_early_q, err_early_d;
  logic        err_no_last_q, err_no_last_d;
  logic        err_ovf_q, err_ovf_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [31:0]       tdata_ext;
  logic              start, tready, accept, last_beat, mem_we;
  logic              unused_inputs;

  assign unused_inputs = ^{S_AXIS_TKEEP, S_AXIS_TSTRB};

  if (DATA_W >= 32) begin : g_wide
    assign tdata_ext = S_AXIS_TDATA[31:0];
  end else begin : g_narrow
    assign tdata_ext = {{(32 - DATA_W){1'b0}}, S_AXIS_TDATA};
  end

  assign start     = FSYNC_IN && (CFG_WIDTH != 16'd0) && (CFG_HEIGHT != 16'd0);
  assign tready    = (state_q == StCapture) && !STALL_MASK[phase_q];
  assign accept    = tready && S_AXIS_TVALID;
  assign last_beat = (pix_count_q == frame_size_q - 32'd1);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    pix_count_d   = pix_count_q;
    checksum_d    = checksum_q;
    frame_size_d  = frame_size_q;
    width_d       = width_q;
    x_d           = x_q;
    y_d           = y_q;
    done_d        = done_q;
    err_early_d   = err_early_q;
    err_no_last_d = err_no_last_q;
    err_ovf_d     = err_ovf_q;
    mem_we        = 1'b0;
    // A valid frame start wins over any beat accepted in the same cycle.
    if (start) begin
      state_d       = StCapture;
      phase_d       = 3'd0;
      pix_count_d   = 32'd0;
      checksum_d    = 32'd0;
      frame_size_d  = 32'(CFG_WIDTH) * 32'(CFG_HEIGHT);
      width_d       = CFG_WIDTH;
      x_d           = 16'd0;
      y_d           = 16'd0;
      done_d        = 1'b0;
      err_early_d   = 1'b0;
      err_no_last_d = 1'b0;
      err_ovf_d     = 1'b0;
    end else begin
      case (state_q)
        StCapture: begin
          phase_d = phase_q + 3'd1;
          if (accept) begin
            if ({1'b0, pix_count_q} < Depth) mem_we = 1'b1;
            else                              err_ovf_d = 1'b1;
            pix_count_d = pix_count_q + 32'd1;
            checksum_d  = checksum_q + tdata_ext;
            if (x_q == width_q - 16'd1) begin
              x_d = 16'd0;
              y_d = y_q + 16'd1;
            end else begin
              x_d = x_q + 16'd1;
            end
            if (last_beat || S_AXIS_TLAST) begin
              state_d = StDone;
              done_d  = 1'b1;
              if (!S_AXIS_TLAST) err_no_last_d = 1'b1;
              if (!last_beat)    err_early_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      phase_q       <= 3'd0;
      pix_count_q   <= 32'd0;
      checksum_q    <= 32'd0;
      frame_size_q  <= 32'd0;
      width_q       <= 16'd0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      done_q        <= 1'b0;
      err_early_q   <= 1'b0;
      err_no_last_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      pix_count_q   <= pix_count_d;
      checksum_q    <= checksum_d;
      frame_size_q  <= frame_size_d;
      width_q       <= width_d;
      x_q           <= x_d;
      y_q           <= y_d;
      done_q        <= done_d;
      err_early_q   <= err_early_d;
      err_no_last_q <= err_no_last_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  // Buffer is not reset; read-before-write gives old data on address collision.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[pix_count_q[ADDR_W-1:0]] <= S_AXIS_TDATA;
    rd_data_q <= mem[RD_ADDR];
  end

  assign S_AXIS_TREADY  = tready;
  assign RD_DATA        = rd_data_q;
  assign BUSY           = (state_q == StCapture);
  assign DONE           = done_q;
  assign PIX_COUNT      = pix_count_q;
  assign CHECKSUM       = checksum_q;
  assign ERR_EARLY_LAST = err_early_q;
  assign ERR_NO_LAST    = err_no_last_q;
  assign ERR_OVERFLOW   = err_ovf_q;

endmodule
